// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file and its
// pending-write scoreboard.
package regfile_pkg;

   localparam int PEND_W = 2;
   localparam logic [PEND_W-1:0] PEND_SAT = 2'd3;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < n) r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write counters: reservations count up, writes count
// down (floored at zero), an unreserved write raises a sticky error.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter int NWR      = 2,
   parameter int ZERO_REG = 1,
   localparam int AW      = clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NWR-1:0]    i_wv,
   input  logic [NWR*AW-1:0] i_waddr,
   input  logic              i_rsv_valid,
   input  logic [AW-1:0]     i_rsv_addr,
   input  logic [NRD*AW-1:0] i_raddr,
   output logic              o_rsv_ready,
   output logic [NRD-1:0]    o_busy,
   output logic              o_err
);

   logic [PEND_W-1:0] r_pend     [NREGS];
   logic              r_err;
   logic [PEND_W-1:0] w_pend_nxt [NREGS];
   logic [1:0]        w_nw       [NREGS];
   logic [2:0]        w_sum      [NREGS];
   logic              w_rsv_zero;
   logic              w_inc;
   logic              w_under;

   // The zero register is never tracked, so its reservations never stall.
   assign w_rsv_zero  = (ZERO_REG != 0) && (i_rsv_addr == '0);
   assign o_rsv_ready = w_rsv_zero || (r_pend[i_rsv_addr] != PEND_SAT);
   assign w_inc       = i_rsv_valid && o_rsv_ready && !w_rsv_zero;
   assign o_err       = r_err;

   always_comb begin
      w_under = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
         w_nw[r] = 2'd0;
         for (int i = 0; i < NWR; i++) begin
            if (i_wv[i] && (i_waddr[i*AW +: AW] == AW'(r))) w_nw[r] = w_nw[r] + 2'd1;
         end
         w_sum[r] = {1'b0, r_pend[r]} + ((w_inc && (i_rsv_addr == AW'(r))) ? 3'd1 : 3'd0);
         w_pend_nxt[r] = (w_sum[r] > {1'b0, w_nw[r]}) ? PEND_W'(w_sum[r] - {1'b0, w_nw[r]}) : '0;
         // Writing more times than the register was reserved for is an underflow.
         if (w_nw[r] > r_pend[r]) w_under = 1'b1;
      end
   end

   always_comb begin
      o_busy = '0;
      for (int k = 0; k < NRD; k++) begin
         o_busy[k] = r_pend[i_raddr[k*AW +: AW]] > w_nw[i_raddr[k*AW +: AW]];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) r_pend[r] <= '0;
         r_err <= 1'b0;
      end else begin
         for (int r = 0; r < NREGS; r++) r_pend[r] <= w_pend_nxt[r];
         r_err <= r_err | w_under;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass and an issue-stage
// destination scoreboard; higher-index write ports take priority.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter int NWR      = 2,
   parameter int ZERO_REG = 1,
   localparam int AW      = clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NWR-1:0]        we,
   input  logic [NWR*AW-1:0]     waddr,
   input  logic [NWR*DATA_W-1:0] wdata,
   input  logic [NRD*AW-1:0]     raddr,
   output logic [NRD*DATA_W-1:0] rdata,
   input  logic                  rsv_valid,
   input  logic [AW-1:0]         rsv_addr,
   output logic                  rsv_ready,
   output logic [NRD-1:0]        busy,
   output logic                  err
);

   logic [DATA_W-1:0] r_regs [NREGS];
   logic [DATA_W-1:0] w_rd   [NRD];
   logic [NWR-1:0]    w_wv;

   // A write is effective only out of reset and when not aimed at the zero register.
   always_comb begin
      w_wv = '0;
      for (int i = 0; i < NWR; i++) begin
         w_wv[i] = we[i] && rst_n && !((ZERO_REG != 0) && (waddr[i*AW +: AW] == '0));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
      end else begin
         for (int i = 0; i < NWR; i++) begin
            if (w_wv[i]) r_regs[waddr[i*AW +: AW]] <= wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NRD; k++) begin
         w_rd[k] = r_regs[raddr[k*AW +: AW]];
         if ((ZERO_REG != 0) && (raddr[k*AW +: AW] == '0)) w_rd[k] = '0;
         for (int i = 0; i < NWR; i++) begin
            if (w_wv[i] && (waddr[i*AW +: AW] == raddr[k*AW +: AW])) w_rd[k] = wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      rdata = '0;
      for (int k = 0; k < NRD; k++) rdata[k*DATA_W +: DATA_W] = w_rd[k];
   end

   rf_scoreboard #(
      .NREGS    (NREGS),
      .NRD      (NRD),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_wv        (w_wv),
      .i_waddr     (waddr),
      .i_rsv_valid (rsv_valid),
      .i_rsv_addr  (rsv_addr),
      .i_raddr     (raddr),
      .o_rsv_ready (rsv_ready),
      .o_busy      (busy),
      .o_err       (err)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp at default parameters (32x32, 2 read, 2 write).
module tb_regfile_mp;

   logic        clk;
   logic        rst_n;
   logic [1:0]  we;
   logic [9:0]  waddr;
   logic [63:0] wdata;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic        rsv_valid;
   logic [4:0]  rsv_addr;
   logic        rsv_ready;
   logic [1:0]  busy;
   logic        err;

   int n_pass  = 0;
   int n_total = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_v;

   regfile_mp dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .raddr     (raddr),
      .rdata     (rdata),
      .rsv_valid (rsv_valid),
      .rsv_addr  (rsv_addr),
      .rsv_ready (rsv_ready),
      .busy      (busy),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      we        = '0;
      waddr     = '0;
      wdata     = '0;
      rsv_valid = 1'b0;
      rsv_addr  = '0;
   endtask

   task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
      we[p]             = 1'b1;
      waddr[p*5 +: 5]   = a;
      wdata[p*32 +: 32] = d;
   endtask

   task automatic rd(input int k, input logic [4:0] a);
      raddr[k*5 +: 5] = a;
   endtask

   task automatic test_reset;
      idle;
      wr(0, 5'd5, 32'hCAFEF00D);
      rd(0, 5'd5);
      rd(1, 5'd0);
      rsv_valid = 1'b1;
      rsv_addr  = 5'd3;
      tick;
      tick;
      n_total++; if (rdata[31:0] !== 32'h0) $display("FAIL rst_rdata0: got %h exp %h", rdata[31:0], 32'h0); else n_pass++;
      n_total++; if (busy !== 2'b00) $display("FAIL rst_busy: got %b exp %b", busy, 2'b00); else n_pass++;
      n_total++; if (rsv_ready !== 1'b1) $display("FAIL rst_rsv_ready: got %b exp 1", rsv_ready); else n_pass++;
      n_total++; if (err !== 1'b0) $display("FAIL rst_err: got %b exp 0", err); else n_pass++;
      #3;
      rst_n = 1'b1;
      idle;
      rd(1, 5'd3);
      tick;
      n_total++; if (rdata[31:0] !== 32'h0) $display("FAIL rst_write_ignored: got %h exp %h", rdata[31:0], 32'h0); else n_pass++;
      n_total++; if (busy[1] !== 1'b0) $display("FAIL rst_rsv_ignored: got %b exp 0", busy[1]); else n_pass++;
   endtask

   task automatic test_underflow_err;
      n_total++; if (err !== 1'b0) $display("FAIL err_pre: got %b exp 0", err); else n_pass++;
      wr(0, 5'd9, 32'h0000_0999);
      tick;
      idle;
      rd(0, 5'd9);
      #1;
      n_total++; if (rdata[31:0] !== 32'h0000_0999) $display("FAIL err_reg9: got %h exp %h", rdata[31:0], 32'h0000_0999); else n_pass++;
      n_total++; if (err !== 1'b1) $display("FAIL err_set: got %b exp 1", err); else n_pass++;
      tick;
      tick;
      tick;
      n_total++; if (err !== 1'b1) $display("FAIL err_sticky: got %b exp 1", err); else n_pass++;
   endtask

   task automatic test_write_read;
      wr(0, 5'd5, 32'h12345678);
      tick;
      idle;
      rd(0, 5'd5);
      rd(1, 5'd0);
      #1;
      n_total++; if (rdata[31:0] !== 32'h12345678) $display("FAIL wr_rd_reg5: got %h exp %h", rdata[31:0], 32'h12345678); else n_pass++;
      n_total++; if (rdata[63:32] !== 32'h0) $display("FAIL wr_rd_reg0: got %h exp %h", rdata[63:32], 32'h0); else n_pass++;
      wr(0, 5'd10, 32'h1111_0010); exp_q.push_back(32'h1111_0010);
      wr(1, 5'd11, 32'h2222_0011); exp_q.push_back(32'h2222_0011);
      tick;
      wr(0, 5'd12, 32'h3333_0012); exp_q.push_back(32'h3333_0012);
      wr(1, 5'd13, 32'h4444_0013); exp_q.push_back(32'h4444_0013);
      tick;
      idle;
      for (int a = 10; a < 14; a += 2) begin
         rd(0, 5'(a));
         rd(1, 5'(a + 1));
         #1;
         exp_v = exp_q.pop_front();
         n_total++; if (rdata[31:0] !== exp_v) $display("FAIL wr_rd_port0 reg%0d: got %h exp %h", a, rdata[31:0], exp_v); else n_pass++;
         exp_v = exp_q.pop_front();
         n_total++; if (rdata[63:32] !== exp_v) $display("FAIL wr_rd_port1 reg%0d: got %h exp %h", a + 1, rdata[63:32], exp_v); else n_pass++;
      end
   endtask

   task automatic test_same_addr;
      idle;
      wr(0, 5'd7, 32'hAAAA0000);
      wr(1, 5'd7, 32'hBBBB0000);
      rd(0, 5'd7);
      #1;
      n_total++; if (rdata[31:0] !== 32'hBBBB0000) $display("FAIL same_addr_bypass: got %h exp %h", rdata[31:0], 32'hBBBB0000); else n_pass++;
      tick;
      idle;
      #1;
      n_total++; if (rdata[31:0] !== 32'hBBBB0000) $display("FAIL same_addr_stored: got %h exp %h", rdata[31:0], 32'hBBBB0000); else n_pass++;
   endtask

   task automatic test_zero_reg;
      wr(1, 5'd0, 32'hDEADBEEF);
      rd(0, 5'd0);
      rsv_valid = 1'b1;
      rsv_addr  = 5'd0;
      #1;
      n_total++; if (rdata[31:0] !== 32'h0) $display("FAIL zero_no_bypass: got %h exp %h", rdata[31:0], 32'h0); else n_pass++;
      n_total++; if (rsv_ready !== 1'b1) $display("FAIL zero_rsv_ready: got %b exp 1", rsv_ready); else n_pass++;
      tick;
      idle;
      #1;
      n_total++; if (rdata[31:0] !== 32'h0) $display("FAIL zero_stored: got %h exp %h", rdata[31:0], 32'h0); else n_pass++;
      n_total++; if (dut.u_sb.r_pend[0] !== 2'd0) $display("FAIL zero_pend: got %0d exp 0", dut.u_sb.r_pend[0]); else n_pass++;
      n_total++; if (busy[0] !== 1'b0) $display("FAIL zero_busy: got %b exp 0", busy[0]); else n_pass++;
   endtask

   task automatic test_saturate;
      logic [1:0] exp_p;
      idle;
      rd(0, 5'd3);
      rsv_valid = 1'b1;
      rsv_addr  = 5'd3;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_total++; if (rsv_ready !== (i < 3)) $display("FAIL sat_ready%0d: got %b exp %b", i, rsv_ready, (i < 3)); else n_pass++;
         tick;
         exp_p = (i < 3) ? 2'(i + 1) : 2'd3;
         n_total++; if (dut.u_sb.r_pend[3] !== exp_p) $display("FAIL sat_pend%0d: got %0d exp %0d", i, dut.u_sb.r_pend[3], exp_p); else n_pass++;
      end
      idle;
      #1;
      n_total++; if (busy[0] !== 1'b1) $display("FAIL sat_busy: got %b exp 1", busy[0]); else n_pass++;
   endtask

   task automatic test_drain;
      wr(0, 5'd3, 32'h11);
      wr(1, 5'd3, 32'h22);
      #1;
      n_total++; if (busy[0] !== 1'b1) $display("FAIL drain2_busy: got %b exp 1", busy[0]); else n_pass++;
      n_total++; if (rdata[31:0] !== 32'h22) $display("FAIL drain2_bypass: got %h exp %h", rdata[31:0], 32'h22); else n_pass++;
      tick;
      idle;
      #1;
      n_total++; if (dut.u_sb.r_pend[3] !== 2'd1) $display("FAIL drain2_pend: got %0d exp 1", dut.u_sb.r_pend[3]); else n_pass++;
      n_total++; if (busy[0] !== 1'b1) $display("FAIL drain1_busy_pre: got %b exp 1", busy[0]); else n_pass++;
      wr(0, 5'd3, 32'h55);
      #1;
      n_total++; if (busy[0] !== 1'b0) $display("FAIL resolve_busy: got %b exp 0", busy[0]); else n_pass++;
      n_total++; if (rdata[31:0] !== 32'h55) $display("FAIL resolve_bypass: got %h exp %h", rdata[31:0], 32'h55); else n_pass++;
      tick;
      idle;
      #1;
      n_total++; if (dut.u_sb.r_pend[3] !== 2'd0) $display("FAIL resolve_pend: got %0d exp 0", dut.u_sb.r_pend[3]); else n_pass++;
      n_total++; if (rdata[31:0] !== 32'h55) $display("FAIL resolve_stored: got %h exp %h", rdata[31:0], 32'h55); else n_pass++;
   endtask

   task automatic test_back_to_back;
      idle;
      rsv_valid = 1'b1;
      rsv_addr  = 5'd6;
      tick;
      n_total++; if (dut.u_sb.r_pend[6] !== 2'd1) $display("FAIL b2b_pend1: got %0d exp 1", dut.u_sb.r_pend[6]); else n_pass++;
      wr(0, 5'd6, 32'h66);
      rd(1, 5'd6);
      #1;
      n_total++; if (busy[1] !== 1'b0) $display("FAIL b2b_busy_bypass: got %b exp 0", busy[1]); else n_pass++;
      tick;
      idle;
      #1;
      n_total++; if (dut.u_sb.r_pend[6] !== 2'd1) $display("FAIL b2b_pend_net: got %0d exp 1", dut.u_sb.r_pend[6]); else n_pass++;
      n_total++; if (busy[1] !== 1'b1) $display("FAIL b2b_busy: got %b exp 1", busy[1]); else n_pass++;
   endtask

   task automatic test_reset_mid;
      idle;
      rsv_valid = 1'b1;
      rsv_addr  = 5'd4;
      tick;
      tick;
      idle;
      rd(0, 5'd5);
      rd(1, 5'd4);
      #1;
      n_total++; if (dut.u_sb.r_pend[4] !== 2'd2) $display("FAIL mid_pend_pre: got %0d exp 2", dut.u_sb.r_pend[4]); else n_pass++;
      n_total++; if (busy[1] !== 1'b1) $display("FAIL mid_busy_pre: got %b exp 1", busy[1]); else n_pass++;
      n_total++; if (rdata[31:0] !== 32'h12345678) $display("FAIL mid_rdata_pre: got %h exp %h", rdata[31:0], 32'h12345678); else n_pass++;
      n_total++; if (err !== 1'b1) $display("FAIL mid_err_pre: got %b exp 1", err); else n_pass++;
      #1;
      rst_n = 1'b0;
      wr(0, 5'd5, 32'hFFFF_FFFF);
      rsv_valid = 1'b1;
      rsv_addr  = 5'd4;
      #1;
      n_total++; if (rdata[31:0] !== 32'h0) $display("FAIL mid_rdata: got %h exp %h", rdata[31:0], 32'h0); else n_pass++;
      n_total++; if (busy !== 2'b00) $display("FAIL mid_busy: got %b exp %b", busy, 2'b00); else n_pass++;
      n_total++; if (rsv_ready !== 1'b1) $display("FAIL mid_rsv_ready: got %b exp 1", rsv_ready); else n_pass++;
      n_total++; if (err !== 1'b0) $display("FAIL mid_err: got %b exp 0", err); else n_pass++;
      n_total++; if (dut.u_sb.r_pend[4] !== 2'd0) $display("FAIL mid_pend4: got %0d exp 0", dut.u_sb.r_pend[4]); else n_pass++;
      n_total++; if (dut.u_sb.r_pend[6] !== 2'd0) $display("FAIL mid_pend6: got %0d exp 0", dut.u_sb.r_pend[6]); else n_pass++;
      tick;
      #3;
      idle;
      rst_n = 1'b1;
      tick;
      n_total++; if (rdata[31:0] !== 32'h0) $display("FAIL mid_reg5_cleared: got %h exp %h", rdata[31:0], 32'h0); else n_pass++;
      n_total++; if (busy !== 2'b00) $display("FAIL mid_busy_after: got %b exp %b", busy, 2'b00); else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0;
      raddr = '0;
      idle;
      test_reset;
      test_underflow_err;
      test_write_read;
      test_same_addr;
      test_zero_reg;
      test_saturate;
      test_drain;
      test_back_to_back;
      test_reset_mid;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of two, at least 4); AW = clog2(NREGS), derived in package function.
REQ-003 SHALL have parameter NRD, default 2, read port count (1..4).
REQ-004 SHALL have parameter NWR, default 2, write port count (1..2).
REQ-005 SHALL have parameter ZERO_REG, default 1, 1 = register 0 hardwired to zero.
REQ-006 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port we  input  NWR  per-port write enable.
REQ-009 SHALL have port waddr  input  NWR*AW  write addresses, port i in slice i.
REQ-010 SHALL have port wdata  input  NWR*DATA_W  write data, port i in slice i.
REQ-011 SHALL have port raddr  input  NRD*AW  read addresses.
REQ-012 SHALL have port rdata  output  NRD*DATA_W  read data, combinational.
REQ-013 SHALL have port rsv_valid  input  1  issue-stage destination reservation request.
REQ-014 SHALL have port rsv_addr  input  AW  register to reserve.
REQ-015 SHALL have port rsv_ready  output  1  reservation accepted this cycle.
REQ-016 SHALL have port busy  output  NRD  read-port source has unresolved pending write.
REQ-017 SHALL have port err  output  1  sticky write-without-reservation flag.

Function
REQ-018 Write: at rising clk, reg[waddr_i] <= wdata_i for each i with we_i=1; writes to reg 0 discarded when ZERO_REG=1.
REQ-019 Same-address writes in one cycle: highest-index port wins, no X.
REQ-020 Read: rdata_k = reg[raddr_k], zero-latency; reg 0 reads 0 when ZERO_REG=1.
REQ-021 Bypass: if any we_i=1 with waddr_i == raddr_k (and not the zero reg), rdata_k = wdata of highest-index matching port.
REQ-022 Scoreboard: 2-bit pending counter pend[r] per register.
REQ-023 pend[r] increments at rising clk when rsv_valid=1, rsv_ready=1, rsv_addr=r, and r not the zero reg.
REQ-024 pend[r] decrements by the number of write ports with we_i=1, waddr_i=r in that cycle, floored at 0.
REQ-025 Simultaneous reserve and write to the same r: net change = +1 minus writes, floored at 0.
REQ-026 rsv_ready = (pend[rsv_addr] != 3); reservation of the zero reg is always ready and not counted.
REQ-027 Saturation: with pend=3, rsv_valid is refused (rsv_ready=0) and pend does not wrap.
REQ-028 busy_k = pend[raddr_k] > number of this-cycle writes to raddr_k; a write resolving the last pending entry clears busy combinationally via bypass.
REQ-029 Underflow: a write (non-zero reg) with pend=0 still updates the register, sets err=1, and err holds until reset.

Reset
REQ-030 On rst_n low, SHALL asynchronously clear all registers, all pend, and err.
REQ-031 While rst_n low: writes and reservations are ignored, bypass is disabled, rdata=0, busy=0, rsv_ready=1, err=0.
REQ-032 Deassertion takes effect at the first rising clk after rst_n goes high.

Structure
REQ-033 Package regfile_pkg SHALL hold the clog2 function, the pend-counter width constant (2), and the saturation constant (3).
REQ-034 Scoreboard SHALL be one sub-module rf_scoreboard (pend array, rsv_ready, busy, err); storage and bypass stay in regfile_mp.

Verification
REQ-035 Reset then write reg5=0x12345678 port0 -> next cycle raddr0=5 reads 0x12345678; raddr1=0 reads 0.
REQ-036 Same cycle port0 and port1 both write reg7 (0xAAAA0000, 0xBBBB0000) while raddr0=7 -> bypass shows 0xBBBB0000; reg7=0xBBBB0000 after the edge.
REQ-037 Reserve reg3 four times back-to-back -> pend 1,2,3, fourth rsv_ready=0, pend stays 3, busy high for raddr=3.
REQ-038 pend[3]=1, write reg3=0x55 with raddr0=3 -> busy0=0 and rdata0=0x55 in the same cycle; pend=0 after the edge.
REQ-039 Write reg9 with pend=0 -> err=1, reg9 updated, err stays high until rst_n low.
REQ-040 Assert rst_n low mid-cycle with pend[4]=2 -> immediate rdata=0, busy=0, rsv_ready=1; all pend cleared.
